pipeline_hazard_ctrl: RTL

- Sequencing controller for the 5-stage MIPS pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Decides each cycle which latches advance, which get a bubble, and when the PC updates, from cache hits, load-use dependences, branch/jump redirects and halt.
- Tracks D-cache waits and halt drain in a small FSM.
- Keeps a saturating stall-cycle counter and a D-cache wait watchdog for the bench and performance reporting.

---
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath: latch enables,
// bubble injection, PC update, D-cache wait / halt tracking and stall statistics.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DWAIT_MAX = 255
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_ren,
  input  logic             mem_wen,
  input  logic             mem_halt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  output logic             pc_en,
  output logic             FDen,
  output logic             DEen,
  output logic             EMen,
  output logic             MWen,
  output logic             FDflush,
  output logic             DEflush,
  output logic             EMflush,
  output logic             MWflush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam int unsigned DW_W = $clog2(DWAIT_MAX + 2);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DW_W-1:0]   dwait_cnt_q, dwait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic pc_en_c, fd_en_c, de_en_c, em_en_c, mw_en_c;
  logic fd_fl_c, de_fl_c, em_fl_c, mw_fl_c;
  logic load_use_c;

  assign load_use_c = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Priority-ordered hazard resolution; first matching condition decides.
  always_comb begin
    pc_en_c = 1'b0;
    fd_en_c = 1'b0;
    de_en_c = 1'b0;
    em_en_c = 1'b0;
    mw_en_c = 1'b0;
    fd_fl_c = 1'b0;
    de_fl_c = 1'b0;
    em_fl_c = 1'b0;
    mw_fl_c = 1'b0;
    state_d = RUN;
    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (mem_halt) begin
      fd_en_c = 1'b1;
      de_en_c = 1'b1;
      em_en_c = 1'b1;
      mw_en_c = 1'b1;
      fd_fl_c = 1'b1;
      de_fl_c = 1'b1;
      em_fl_c = 1'b1;
      state_d = HALTED;
    end else if ((mem_ren || mem_wen) && !dhit) begin
      state_d = DWAIT;
    end else if (ex_branch_taken) begin
      pc_en_c = 1'b1;
      fd_en_c = 1'b1;
      de_en_c = 1'b1;
      em_en_c = 1'b1;
      mw_en_c = 1'b1;
      fd_fl_c = 1'b1;
      de_fl_c = 1'b1;
    end else if (load_use_c) begin
      de_en_c = 1'b1;
      em_en_c = 1'b1;
      mw_en_c = 1'b1;
      de_fl_c = 1'b1;
    end else if (id_jump) begin
      pc_en_c = 1'b1;
      fd_en_c = 1'b1;
      de_en_c = 1'b1;
      em_en_c = 1'b1;
      mw_en_c = 1'b1;
      fd_fl_c = 1'b1;
    end else if (!ihit) begin
      fd_en_c = 1'b1;
      de_en_c = 1'b1;
      em_en_c = 1'b1;
      mw_en_c = 1'b1;
      fd_fl_c = 1'b1;
    end else begin
      pc_en_c = 1'b1;
      fd_en_c = 1'b1;
      de_en_c = 1'b1;
      em_en_c = 1'b1;
      mw_en_c = 1'b1;
    end
  end

  // Wait watchdog and stall statistics; both saturate instead of wrapping.
  always_comb begin
    dwait_cnt_d   = '0;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;
    if (state_q == DWAIT && state_d == DWAIT && dwait_cnt_q != DW_W'(DWAIT_MAX)) begin
      dwait_cnt_d = dwait_cnt_q + DW_W'(1);
    end else if (state_q == DWAIT && state_d == DWAIT) begin
      dwait_cnt_d = dwait_cnt_q;
    end
    if (state_q == DWAIT && dwait_cnt_q == DW_W'(DWAIT_MAX)) begin
      mem_timeout_d = 1'b1;
    end
    if (!pc_en_c && state_q != HALTED && stall_count_q != {CNT_W{1'b1}}) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= RUN;
      dwait_cnt_q   <= '0;
      stall_count_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwait_cnt_q   <= dwait_cnt_d;
      stall_count_q <= stall_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Reset forces every control output low regardless of the inputs.
  assign pc_en       = nRST & pc_en_c;
  assign FDen        = nRST & fd_en_c;
  assign DEen        = nRST & de_en_c;
  assign EMen        = nRST & em_en_c;
  assign MWen        = nRST & mw_en_c;
  assign FDflush     = nRST & fd_fl_c;
  assign DEflush     = nRST & de_fl_c;
  assign EMflush     = nRST & em_fl_c;
  assign MWflush     = nRST & mw_fl_c;
  assign halted      = nRST & (state_q == HALTED);
  assign stall_count = stall_count_q;
  assign mem_timeout = mem_timeout_q;

endmodule
